// File: rtl/serial_adder.sv
// Digit-serial adder: one DIGIT-bit ripple slice plus a carry flop, LSB first, valid/ready on both sides.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input that turns the operation into a - b.
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("serial_adder: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, acc;
    logic [CW-1:0]    cnt;
    logic             cy;

    logic             accept, last;
    logic [DIGIT:0]   slice;
    logic [WIDTH-1:0] acc_shift;
    logic [WIDTH-1:0] b_load;
    logic             cy_load;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_ready && in_valid;
    assign last      = (state == RUN) && (cnt == CW'(N - 1));

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction as a + ~b + 1; the final carry then reads as "no borrow".
    assign b_load  = sub ? ~b : b;
    assign cy_load = sub ? 1'b1 : cin;
`else
    assign b_load  = b;
    assign cy_load = cin;
`endif

    assign slice     = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, cy};
    // New digit enters at the MSB end so the finished word is aligned after N shifts.
    assign acc_shift = WIDTH'({slice[DIGIT-1:0], acc} >> DIGIT);

    // NOTE: always_comb gives every output a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            acc   <= '0;
            cnt   <= '0;
            cy    <= 1'b0;
            sum   <= '0;
            carry <= 1'b0;
        end else if (accept) begin
            a_sr <= a;
            b_sr <= b_load;
            cy   <= cy_load;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sr <= a_sr >> DIGIT;
            b_sr <= b_sr >> DIGIT;
            acc  <= acc_shift;
            cy   <= slice[DIGIT];
            cnt  <= cnt + 1'b1;
            if (last) begin
                sum   <= acc_shift;
                carry <= slice[DIGIT];
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: transaction-level reference model plus per-cycle output compare.
module tb_serial_adder;

    localparam int WIDTH = 16;
    localparam int DIGIT = 1;
    localparam int N     = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             carry;

    int ncmp = 0;
    int nbad = 0;

    serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .carry    (carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: a job is pending for N edges after acceptance, then its result is offered until taken.
    logic           m_busy = 1'b0, m_done = 1'b0;
    int             m_left = 0;
    logic [WIDTH:0] m_res = '0;
    logic [WIDTH-1:0] exp_sum = '0;
    logic           exp_carry = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_left = 0;
            exp_sum = '0;  exp_carry = 1'b0;
        end else if (!m_busy && !m_done) begin
            if (in_valid) begin
`ifdef SERIAL_ADDER_SUB_EN
                if (sub) m_res = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                else
`endif
                m_res = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
                m_busy = 1'b1;
                m_left = N;
            end
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0; m_done = 1'b1;
                exp_sum = m_res[WIDTH-1:0];
                exp_carry = m_res[WIDTH];
            end
        end else if (out_ready) begin
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        check("in_ready",  in_ready,  !m_busy && !m_done);
        check("out_valid", out_valid, m_done);
        check("sum",       sum,       exp_sum);
        check("carry",     carry,     exp_carry);
    end

    // One full transaction; operands are scrambled after acceptance and during backpressure.
    task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc,
                         input logic tsub, input int hold, input bit pin,
                         input logic [WIDTH-1:0] psum, input logic pcar);
        int k;
        k = 0;
        while (!in_ready && k < 2*N) begin @(negedge clk); k++; end
        if (!in_ready) check("wait_in_ready", 0, 1);
        a = ta; b = tb_v; cin = tc; sub = tsub; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < N + 4) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'($urandom);
            @(negedge clk);
            k++;
        end
        if (!out_valid) check("wait_out_valid", 0, 1);
        if (pin) begin
            check("latency", k, N);
            check("pin_sum", sum, psum);
            check("pin_carry", carry, pcar);
        end
        for (int i = 0; i < hold; i++) begin
            a = $urandom; b = $urandom; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (pin) check("pin_in_ready_after_take", in_ready, 1);
    endtask

    initial begin
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_carry", carry, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(16'h0000, 16'h0000, 1'b0, 1'b0, 0, 1'b1, 16'h0000, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b1, 16'h0000, 1'b1);
        do_op(16'h1234, 16'h4321, 1'b1, 1'b0, 5, 1'b1, 16'h5556, 1'b0);
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 2, 1'b1, 16'h0000, 1'b1);
`ifdef SERIAL_ADDER_SUB_EN
        do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0, 1'b1, 16'h0002, 1'b1);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b1, 16'hFFFE, 1'b0);
        sub = 1'b0;
`endif

        // Abort mid-RUN: reset after seven RUN edges must clear everything at once.
        a = 16'hABCD; b = 16'h1111; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_carry", carry, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 2) @(negedge clk);
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b1, 16'h0100, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = $urandom; rb = $urandom;
            if (t % 10 == 0) begin ra = '1; rb = '1; end
            do_op(ra, rb, 1'($urandom), 1'b0, int'($urandom_range(0, 3)), 1'b0, '0, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised multi-cycle adder built around a single DIGIT-bit ripple slice and a carry flip-flop. It adds two WIDTH-bit operands plus carry-in, processing DIGIT bits per clock, LSB first. A valid/ready handshake is used on both input and output. It is the area-lean replacement for wide combinational adders in the Hack ALU datapath.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
DIGIT, 1, bits processed per cycle; N = WIDTH/DIGIT is the number of RUN cycles.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands a, b, cin are valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in.
out_valid  output  1  sum/carry hold a completed result.
out_ready  input  1  consumer takes the result.
sum  output  WIDTH  result, (a + b + cin) mod 2^WIDTH.
carry  output  1  carry out of bit WIDTH-1.
sub  input  1  only present when SERIAL_ADDER_SUB_EN is defined.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: in_ready=1, out_valid=0, sum=0, carry=0, digit counter=0, carry flop=0.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded combinationally from the state register.
- Accept edge (IDLE, in_valid=1):
  - operands load into shift registers; carry flop <= cin; count <= 0; state <= RUN.
  - Operand changes after the accept edge have no effect.
- RUN, each edge:
  - low DIGIT bits of the A/B shift registers plus the carry flop are added.
  - the DIGIT result bits shift into the MSB end of the result shift register.
  - carry flop <= slice carry-out; operands shift right by DIGIT; count++.
- On the RUN edge where count==N-1:
  - the completed result and final carry are copied to the sum/carry output registers.
  - state <= DONE.
- Latency: out_valid rises exactly N cycles after the accept edge (16 for defaults, 4 for WIDTH=16, DIGIT=4).
- DONE:
  - sum/carry are stable; state is held while out_ready=0, indefinitely.
  - Edge with out_ready=1: state <= IDLE.
  - in_ready is 0 in DONE, so a new accept cannot occur in the same cycle as the output handshake.
  - Maximum throughput is one result per N+2 cycles.
- sum/carry output registers change only on the completing RUN edge or on reset. They keep the last result through IDLE and RUN.
- Arithmetic is unsigned modulo 2^WIDTH. carry is the true bit WIDTH of a+b+cin.
- Reset mid-operation (any state): immediate return to IDLE and all reset values. The partial result is discarded and no out_valid pulse is produced.
- in_valid while not IDLE is ignored; the operands are not captured.
- out_ready while not DONE is ignored.
- WIDTH % DIGIT != 0 is illegal; the block raises an elaboration-time error.

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - the sub input port exists and is sampled on the accept edge.
  - When sub=1, the B shift register loads ~b and the carry flop loads 1 (cin is ignored). Result = a - b mod 2^WIDTH.
  - carry = 1 means no borrow (a >= b unsigned).
- Not defined: no sub port; the block only adds, exactly as described above.

Test Plan:
- Reset, then a=0, b=0, cin=0 -> out_valid after 16 cycles; sum=0x0000, carry=0; in_ready low from accept until return to IDLE.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, carry=1. a=0x1234, b=0x4321, cin=1 -> sum=0x5556, carry=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum/carry/out_valid stable. In the same period, in_valid=1 with new operands is not accepted. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-RUN: assert rst_n=0 at RUN count 7 -> outputs immediately at reset values, no out_valid. A subsequent 0x00FF+0x0001 gives sum=0x0100, carry=0.
- DIGIT=4 build: a=0x8000, b=0x8000 -> out_valid 4 cycles after accept; sum=0x0000, carry=1.
- With SERIAL_ADDER_SUB_EN, sub=1: a=0x0007, b=0x0005 -> sum=0x0002, carry=1. a=0x0005, b=0x0007 -> sum=0xFFFE, carry=0.
